// File: rtl/pe_pkg.sv
// Shared types for the PE output path.
// Psum width and collector state encoding.
package pe_pkg;

    localparam int PSUM_W = 24;

    typedef logic signed [PSUM_W-1:0] psum_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } coll_state_e;

endpackage

// File: rtl/opsum_fifo.sv
// Synchronous first-word-fall-through FIFO for opsums.
// The head entry is visible on rdata whenever empty is low.
module opsum_fifo
    import pe_pkg::*;
#(
    parameter int DATA_W = PSUM_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_cnt;
    logic              w_push;
    logic              w_pop;

    assign full   = (r_cnt == FULL_CNT);
    assign empty  = (r_cnt == '0);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign rdata  = r_mem[r_rptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage array needs no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= wdata;
    end

endmodule

// File: rtl/opsum_collector.sv
// Drains PE opsums through a small FIFO into consecutive GLB words.
// Define OPSUM_RELU_EN to clamp negative psums to zero at enqueue.
module opsum_collector
    import pe_pkg::*;
#(
    parameter int DATA_W = PSUM_W,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic [CNT_W-1:0]  cfg_num,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic              opsum_enable,
    input  logic [DATA_W-1:0] opsum_noc,
    output logic              opsum_ready,
    output logic              glb_wen,
    output logic [ADDR_W-1:0] glb_addr,
    output logic [DATA_W-1:0] glb_wdata,
    input  logic              glb_wready,
    output logic              busy,
    output logic              done
);

    coll_state_e       r_state;
    coll_state_e       w_state_nxt;
    logic [CNT_W-1:0]  r_num;
    logic [CNT_W-1:0]  r_rcv;
    logic [CNT_W-1:0]  r_wr;
    logic [ADDR_W-1:0] r_addr;

    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_head;
    logic [DATA_W-1:0] w_enq;
    logic              w_acc_in;
    logic              w_acc_out;
    logic              w_last;
    logic              w_start;

`ifdef OPSUM_RELU_EN
    assign w_enq = opsum_noc[DATA_W-1] ? '0 : opsum_noc;
`else
    assign w_enq = opsum_noc;
`endif

    assign w_acc_in  = opsum_enable && opsum_ready;
    assign w_acc_out = glb_wen && glb_wready;
    assign w_last    = w_acc_out && (r_wr == r_num - 1'b1);
    assign w_start   = (r_state == IDLE) && cfg_start;

    opsum_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (w_acc_in),
        .pop   (w_acc_out),
        .wdata (w_enq),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next state and handshake outputs; wdata is gated so it reads 0 when idle.
    always_comb begin
        w_state_nxt = r_state;
        opsum_ready = 1'b0;
        glb_wen     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        glb_addr    = r_addr;
        glb_wdata   = '0;
        unique case (r_state)
            IDLE: begin
                if (cfg_start)
                    w_state_nxt = (cfg_num == '0) ? DONE : RUN;
            end
            RUN: begin
                busy        = 1'b1;
                opsum_ready = !w_full && (r_rcv != r_num);
                glb_wen     = !w_empty;
                glb_wdata   = w_empty ? '0 : w_head;
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Job length, transfer counters and write address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_num  <= '0;
            r_rcv  <= '0;
            r_wr   <= '0;
            r_addr <= '0;
        end else if (w_start) begin
            r_num  <= cfg_num;
            r_rcv  <= '0;
            r_wr   <= '0;
            r_addr <= cfg_base_addr;
        end else begin
            if (w_acc_in) r_rcv <= r_rcv + 1'b1;
            if (w_acc_out) begin
                r_wr   <= r_wr + 1'b1;
                r_addr <= r_addr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_opsum_collector.sv
// Scoreboard bench for opsum_collector.
// Honours OPSUM_RELU_EN in its expected-value model.
module tb_opsum_collector;

    localparam int DATA_W = 24;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 10;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              rst;
    logic              cfg_start;
    logic [CNT_W-1:0]  cfg_num;
    logic [ADDR_W-1:0] cfg_base_addr;
    logic              opsum_enable;
    logic [DATA_W-1:0] opsum_noc;
    logic              opsum_ready;
    logic              glb_wen;
    logic [ADDR_W-1:0] glb_addr;
    logic [DATA_W-1:0] glb_wdata;
    logic              glb_wready;
    logic              busy;
    logic              done;

    opsum_collector #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_start     (cfg_start),
        .cfg_num       (cfg_num),
        .cfg_base_addr (cfg_base_addr),
        .opsum_enable  (opsum_enable),
        .opsum_noc     (opsum_noc),
        .opsum_ready   (opsum_ready),
        .glb_wen       (glb_wen),
        .glb_addr      (glb_addr),
        .glb_wdata     (glb_wdata),
        .glb_wready    (glb_wready),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int last_wr_cyc = 0;
    int done_cyc = 0;
    logic [ADDR_W-1:0] m_addr = '0;

    task automatic expect_eq(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] model_val(input logic [DATA_W-1:0] v);
`ifdef OPSUM_RELU_EN
        return v[DATA_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Monitor: record accepted inputs, check accepted writes in order.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            if (opsum_enable && opsum_ready) begin
                sb.push_back('{a: m_addr, d: model_val(opsum_noc)});
                m_addr = m_addr + 1'b1;
                acc_cnt++;
            end
            if (glb_wen && glb_wready) begin
                wr_cnt++;
                last_wr_cyc = cyc;
                if (sb.size() == 0) begin
                    expect_eq("spurious_wr", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    expect_eq("wr_addr", 64'(glb_addr), 64'(e.a));
                    expect_eq("wr_data", 64'(glb_wdata), 64'(e.d));
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int num, input int base);
        cfg_num       = CNT_W'(num);
        cfg_base_addr = ADDR_W'(base);
        cfg_start     = 1'b1;
        m_addr        = ADDR_W'(base);
        tick();
        cfg_start     = 1'b0;
    endtask

    task automatic send(input int v);
        bit ok;
        ok = 1'b0;
        opsum_enable = 1'b1;
        opsum_noc    = DATA_W'(v);
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = opsum_ready;
            tick();
        end
        if (!ok) expect_eq("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle(input int budget);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < budget && !idle; i++) begin
            @(negedge clk);
            idle = !busy;
        end
        if (!idle) expect_eq("idle_timeout", 64'(busy), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int vals[8];
        int d0, w0, a0, v;
        vals = '{2, -22, 19, 18, -20, -18, 4, 41};

        rst = 1'b0;
        cfg_start = 1'b0;
        cfg_num = '0;
        cfg_base_addr = '0;
        opsum_enable = 1'b0;
        opsum_noc = '0;
        glb_wready = 1'b0;
        tick();
        tick();
        expect_eq("rst_ready", 64'(opsum_ready), 64'd0);
        expect_eq("rst_wen", 64'(glb_wen), 64'd0);
        expect_eq("rst_busy", 64'(busy), 64'd0);
        expect_eq("rst_done", 64'(done), 64'd0);
        rst = 1'b1;
        tick();

        // Test 1: reset with two entries queued.
        start_job(8, 'h100);
        send(5);
        send(-7);
        opsum_enable = 1'b0;
        expect_eq("t1_wen_pre", 64'(glb_wen), 64'd1);
        #2 rst = 1'b0;
        #1;
        expect_eq("t1_ready", 64'(opsum_ready), 64'd0);
        expect_eq("t1_wen", 64'(glb_wen), 64'd0);
        expect_eq("t1_addr", 64'(glb_addr), 64'd0);
        expect_eq("t1_wdata", 64'(glb_wdata), 64'd0);
        expect_eq("t1_busy", 64'(busy), 64'd0);
        expect_eq("t1_done", 64'(done), 64'd0);
        sb.delete();
        tick();
        rst = 1'b1;
        glb_wready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            expect_eq("t1_post_busy", 64'(busy), 64'd0);
            expect_eq("t1_post_wen", 64'(glb_wen), 64'd0);
        end
        tick();

        // Test 2 (and 6): back-to-back stream of eight.
        d0 = done_cnt;
        w0 = wr_cnt;
        start_job(8, 'h010);
        for (int i = 0; i < 8; i++) send(vals[i]);
        opsum_enable = 1'b0;
        wait_idle(50);
        expect_eq("t2_writes", 64'(wr_cnt - w0), 64'd8);
        expect_eq("t2_done_cnt", 64'(done_cnt - d0), 64'd1);
        expect_eq("t2_done_lat", 64'(done_cyc - last_wr_cyc), 64'd1);
        expect_eq("t2_sb_empty", 64'(sb.size()), 64'd0);

        // Test 3: GLB stall, FIFO fills, triple held.
        w0 = wr_cnt;
        a0 = acc_cnt;
        start_job(6, 'h040);
        glb_wready = 1'b0;
        v = 100;
        opsum_enable = 1'b1;
        opsum_noc = DATA_W'(v);
        for (int i = 0; i < 10; i++) begin
            bit r;
            @(negedge clk);
            if (i >= 1) begin
                expect_eq("t3_hold_wen", 64'(glb_wen), 64'd1);
                expect_eq("t3_hold_addr", 64'(glb_addr), 64'h040);
                expect_eq("t3_hold_data", 64'(glb_wdata), 64'd100);
            end
            r = opsum_ready;
            tick();
            if (r) begin
                v++;
                opsum_noc = DATA_W'(v);
            end
        end
        expect_eq("t3_accepts", 64'(acc_cnt - a0), 64'(DEPTH));
        expect_eq("t3_ready_full", 64'(opsum_ready), 64'd0);
        glb_wready = 1'b1;
        send(v);
        send(v + 1);
        opsum_enable = 1'b0;
        wait_idle(50);
        expect_eq("t3_writes", 64'(wr_cnt - w0), 64'd6);
        expect_eq("t3_sb_empty", 64'(sb.size()), 64'd0);

        // Test 4: address wrap, start while busy ignored.
        w0 = wr_cnt;
        start_job(4, 'h3FE);
        send(11);
        send(12);
        opsum_enable = 1'b0;
        cfg_num = 8'd7;
        cfg_base_addr = '0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        expect_eq("t4_busy", 64'(busy), 64'd1);
        send(13);
        send(14);
        opsum_enable = 1'b0;
        wait_idle(50);
        expect_eq("t4_writes", 64'(wr_cnt - w0), 64'd4);
        expect_eq("t4_next_addr", 64'(glb_addr), 64'h002);
        expect_eq("t4_sb_empty", 64'(sb.size()), 64'd0);

        // Test 5a: zero-length job.
        d0 = done_cnt;
        w0 = wr_cnt;
        cfg_num = '0;
        cfg_base_addr = ADDR_W'('h123);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        @(negedge clk);
        expect_eq("t5_done", 64'(done), 64'd1);
        expect_eq("t5_wen", 64'(glb_wen), 64'd0);
        @(negedge clk);
        expect_eq("t5_done_end", 64'(done), 64'd0);
        expect_eq("t5_busy_end", 64'(busy), 64'd0);
        expect_eq("t5_done_cnt", 64'(done_cnt - d0), 64'd1);
        expect_eq("t5_no_wr", 64'(wr_cnt - w0), 64'd0);
        tick();

        // Test 5b: ninth value offered after eight received.
        w0 = wr_cnt;
        start_job(8, 'h200);
        for (int i = 1; i <= 8; i++) send(i);
        glb_wready = 1'b0;
        opsum_noc = DATA_W'(99);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            expect_eq("t5_ninth_ready", 64'(opsum_ready), 64'd0);
            expect_eq("t5_ninth_busy", 64'(busy), 64'd1);
        end
        tick();
        opsum_enable = 1'b0;
        glb_wready = 1'b1;
        wait_idle(50);
        expect_eq("t5_writes", 64'(wr_cnt - w0), 64'd8);
        expect_eq("t5_sb_empty", 64'(sb.size()), 64'd0);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
